// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-beat initiator: valid/ready command stream in, in-order responses out.
// Optional AHB_MASTER_ERRCANCEL_EN: drop the pending address phase on an ERROR and report it as failed.
module ahb_lite_cmd_master #(
    parameter int          AW   = 32,
    parameter logic [3:0]  PROT = 4'b0011
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [1:0]    cmd_size,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          busy,
    output logic [31:0]   HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic          HMASTLOCK,
    output logic [31:0]   HWDATA,
    input  logic [31:0]   HRDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    typedef struct packed {
        logic          vld;
        logic          write;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } a_slot_t;

    typedef struct packed {
        logic        vld;
        logic        write;
        logic [31:0] wdata;
    } d_slot_t;

    a_slot_t     a_q, a_d;
    d_slot_t     d_q, d_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rdy_q, rdy_d;
    logic        cxl_q, cxl_d;

    logic        errfirst, cancel, accept, ready_w;
    logic [1:0]  size_n;
    logic [31:0] haddr_w;

    always_comb begin
        errfirst = d_q.vld && HRESP && !HREADY;
`ifdef AHB_MASTER_ERRCANCEL_EN
        cancel  = errfirst && a_q.vld;
        ready_w = rdy_q && !errfirst && (!a_q.vld || HREADY);
`else
        cancel  = 1'b0;
        ready_w = rdy_q && (!a_q.vld || (HREADY && !errfirst));
`endif
        accept = cmd_valid && ready_w;
        size_n = (cmd_size == 2'b11) ? 2'b10 : cmd_size;
    end

    always_comb begin
        a_d         = a_q;
        d_d         = d_q;
        cxl_d       = cxl_q;
        rdy_d       = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;

        if (HREADY) begin
            d_d.vld   = a_q.vld;
            d_d.write = a_q.write;
            d_d.wdata = a_q.wdata;
        end

        // An empty A slot may load even during a wait state (IDLE -> NONSEQ is legal).
        if (cancel)
            a_d.vld = 1'b0;
        else if (accept)
            a_d = '{vld: 1'b1, write: cmd_write, size: size_n, addr: cmd_addr, wdata: cmd_wdata};
        else if (HREADY)
            a_d.vld = 1'b0;

        // The erroring transfer reports first; the cancelled one follows a cycle later.
        if (d_q.vld && HREADY) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = HRESP;
            rsp_rdata_d = d_q.write ? 32'h0 : HRDATA;
        end else if (cxl_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            cxl_d       = 1'b0;
        end
        if (cancel)
            cxl_d = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_q         <= '0;
            d_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rdy_q       <= 1'b0;
            cxl_q       <= 1'b0;
        end else begin
            a_q         <= a_d;
            d_q         <= d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rdy_q       <= rdy_d;
            cxl_q       <= cxl_d;
        end
    end

    always_comb begin
        haddr_w         = 32'h0;
        haddr_w[AW-1:0] = a_q.addr;
    end

    assign cmd_ready = ready_w;
    assign HADDR     = haddr_w;
    assign HTRANS    = a_q.vld ? 2'b10 : 2'b00;
    assign HWRITE    = a_q.write;
    assign HSIZE     = {1'b0, a_q.size};
    assign HBURST    = 3'b000;
    assign HPROT     = PROT;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = d_q.vld ? d_q.wdata : 32'h0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = a_q.vld || d_q.vld || rsp_valid_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master with a small wait/error-capable AHB slave model.
// Expectations follow AHB_MASTER_ERRCANCEL_EN when it is defined for the build.
module tb_ahb_lite_cmd_master;

    logic        HCLK, HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    int checks = 0;
    int errors = 0;

    ahb_lite_cmd_master #(.AW(32), .PROT(4'b0011)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Slave model: word memory, programmable wait states, two-cycle ERROR on err_addr.
    logic [31:0] mem [0:63];
    logic        s_vld, s_write, s_err;
    logic [31:0] s_addr;
    int          s_wcnt;
    int          waits;
    logic        err_en;
    logic [31:0] err_addr;

    always_comb begin
        if (s_vld && s_err) begin
            HRESP  = 1'b1;
            HREADY = (s_wcnt >= 1);
        end else begin
            HRESP  = 1'b0;
            HREADY = !s_vld || (s_wcnt >= waits);
        end
        HRDATA = (s_vld && !s_write) ? mem[s_addr[7:2]] : 32'h0;
    end

    always @(posedge HCLK) begin
        if (HRESET) begin
            s_vld   <= 1'b0;
            s_write <= 1'b0;
            s_err   <= 1'b0;
            s_addr  <= 32'h0;
            s_wcnt  <= 0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (HREADY) begin
            if (s_vld && s_write && !s_err) mem[s_addr[7:2]] <= HWDATA;
            s_vld   <= HTRANS[1];
            s_addr  <= HADDR;
            s_write <= HWRITE;
            s_err   <= err_en && HTRANS[1] && (HADDR == err_addr);
            s_wcnt  <= 0;
        end else begin
            s_wcnt <= s_wcnt + 1;
        end
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = wd;
    endtask

    task automatic idle_cmd;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_size  = 2'b00;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
    endtask

    task automatic test_reset;
        HRESET = 1'b1; waits = 0; err_en = 1'b0; err_addr = 32'h0;
        idle_cmd();
        tick(); tick();
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans act=%0h exp=0", HTRANS); end
        checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr act=%0h exp=0", HADDR); end
        checks++; if ({HWRITE, HSIZE, HBURST, HMASTLOCK} !== 8'h00) begin errors++; $display("FAIL rst_ctrl act=%0h exp=0", {HWRITE, HSIZE, HBURST, HMASTLOCK}); end
        checks++; if (HPROT !== 4'b0011) begin errors++; $display("FAIL rst_hprot act=%0h exp=3", HPROT); end
        checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata act=%0h exp=0", HWDATA); end
        checks++; if ({rsp_valid, rsp_err, busy, cmd_ready} !== 4'b0000) begin errors++; $display("FAIL rst_flags act=%0b exp=0000", {rsp_valid, rsp_err, busy, cmd_ready}); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata act=%0h exp=0", rsp_rdata); end
        HRESET = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise act=%0b exp=1", cmd_ready); end
    endtask

    task automatic test_write_read;
        drive_cmd(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready act=%0b exp=1", cmd_ready); end
        tick();
        checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL wr_htrans act=%0h exp=2", HTRANS); end
        checks++; if (HWRITE !== 1'b1 || HADDR !== 32'h10) begin errors++; $display("FAIL wr_addr act=%0b/%0h exp=1/10", HWRITE, HADDR); end
        drive_cmd(1'b0, 2'b10, 32'h10, 32'h0);
        tick();
        idle_cmd();
        checks++; if (HTRANS !== 2'b10 || HWRITE !== 1'b0) begin errors++; $display("FAIL rd_htrans act=%0h/%0b exp=2/0", HTRANS, HWRITE); end
        checks++; if (HWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_hwdata act=%0h exp=deadbeef", HWDATA); end
        tick();
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL wr_idle act=%0h exp=0", HTRANS); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp act=%0b/%0b/%0h exp=1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp act=%0b/%0b/%0h exp=1/0/deadbeef", rsp_valid, rsp_err, rsp_rdata); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_rd_done act=%0b/%0b exp=0/0", rsp_valid, busy); end
    endtask

    task automatic test_wait_states;
        waits = 2;
        drive_cmd(1'b0, 2'b00, 32'h3, 32'h0);
        tick();
        idle_cmd();
        checks++; if (HSIZE !== 3'b000) begin errors++; $display("FAIL ws_hsize act=%0h exp=0", HSIZE); end
        for (int c = 0; c < 6; c++) begin
            checks++; if (HTRANS !== ((c == 0) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL ws_htrans c=%0d act=%0h", c, HTRANS); end
            if (c < 3) begin
                checks++; if (HADDR !== 32'h3) begin errors++; $display("FAIL ws_haddr c=%0d act=%0h exp=3", c, HADDR); end
            end
            checks++; if (rsp_valid !== (c == 4)) begin errors++; $display("FAIL ws_rsp_valid c=%0d act=%0b exp=%0b", c, rsp_valid, (c == 4)); end
            checks++; if (busy !== (c <= 4)) begin errors++; $display("FAIL ws_busy c=%0d act=%0b exp=%0b", c, busy, (c <= 4)); end
            if (c == 4) begin
                checks++; if (rsp_rdata !== 32'hA000_0000 || rsp_err !== 1'b0) begin errors++; $display("FAIL ws_rdata act=%0h/%0b exp=a0000000/0", rsp_rdata, rsp_err); end
            end
            tick();
        end
        waits = 0;
    endtask

    task automatic test_back_to_back;
        drive_cmd(1'b1, 2'b10, 32'h20, 32'h0);
        for (int c = 0; c < 11; c++) begin
            tick();
            checks++; if (HTRANS !== ((c < 8) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL b2b_htrans c=%0d act=%0h", c, HTRANS); end
            checks++; if (rsp_valid !== (c >= 2 && c < 10)) begin errors++; $display("FAIL b2b_rsp_valid c=%0d act=%0b", c, rsp_valid); end
            if (c < 8) begin
                checks++; if (HADDR !== 32'h20 + 4 * c || HSIZE !== 3'b010) begin errors++; $display("FAIL b2b_addr c=%0d act=%0h/%0h", c, HADDR, HSIZE); end
            end
            if (c >= 1 && c <= 8) begin
                checks++; if (HWDATA !== 32'(c - 1)) begin errors++; $display("FAIL b2b_hwdata c=%0d act=%0h exp=%0h", c, HWDATA, c - 1); end
            end
            if (c < 7) begin
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d act=%0b exp=1", c, cmd_ready); end
                // Odd commands use size 3, which must go out as a word.
                drive_cmd(1'b1, ((c + 1) % 2 == 1) ? 2'b11 : 2'b10, 32'h20 + 4 * (c + 1), 32'(c + 1));
            end else begin
                idle_cmd();
            end
        end
    endtask

    task automatic test_error;
        logic cxl;
`ifdef AHB_MASTER_ERRCANCEL_EN
        cxl = 1'b1;
`else
        cxl = 1'b0;
`endif
        err_en = 1'b1; err_addr = 32'h40;
        drive_cmd(1'b0, 2'b10, 32'h40, 32'h0);
        tick();
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h40) begin errors++; $display("FAIL err_first_addr act=%0h/%0h exp=2/40", HTRANS, HADDR); end
        drive_cmd(1'b0, 2'b10, 32'h44, 32'h0);
        tick();
        idle_cmd();
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h44) begin errors++; $display("FAIL err_second_addr act=%0h/%0h exp=2/44", HTRANS, HADDR); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL err_ready act=%0b exp=0", cmd_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_first_cycle_rsp act=%0b exp=0", rsp_valid); end
        checks++; if (HTRANS !== (cxl ? 2'b00 : 2'b10)) begin errors++; $display("FAIL err_cancel_htrans act=%0h exp=%0h", HTRANS, cxl ? 2'b00 : 2'b10); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL err_rsp1 act=%0b/%0b exp=1/1", rsp_valid, rsp_err); end
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL err_idle act=%0h exp=0", HTRANS); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== cxl) begin errors++; $display("FAIL err_rsp2 act=%0b/%0b exp=1/%0b", rsp_valid, rsp_err, cxl); end
        checks++; if (rsp_rdata !== (cxl ? 32'h0 : 32'hA000_0011)) begin errors++; $display("FAIL err_rsp2_rdata act=%0h exp=%0h", rsp_rdata, cxl ? 32'h0 : 32'hA000_0011); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_done act=%0b/%0b exp=0/0", rsp_valid, busy); end
        err_en = 1'b0;
    endtask

    task automatic test_reset_inflight;
        waits = 3;
        drive_cmd(1'b0, 2'b10, 32'h8, 32'h0);
        tick();
        idle_cmd();
        checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL rif_htrans act=%0h exp=2", HTRANS); end
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rif_busy act=%0b exp=1", busy); end
        HRESET = 1'b1;
        tick();
        checks++; if (HTRANS !== 2'b00 || HWDATA !== 32'h0) begin errors++; $display("FAIL rif_idle act=%0h/%0h exp=0/0", HTRANS, HWDATA); end
        checks++; if ({rsp_valid, cmd_ready, busy} !== 3'b000) begin errors++; $display("FAIL rif_flags act=%0b exp=000", {rsp_valid, cmd_ready, busy}); end
        HRESET = 1'b0; waits = 0;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rif_ready act=%0b exp=1", cmd_ready); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rif_no_rsp c=%0d act=%0b exp=0", c, rsp_valid); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_back_to_back();
        test_error();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
